// File: rtl/store_unit_if.sv
// store_unit_if: store-request and data-memory write bus of the MEM-stage
// store unit.
//   master : store_unit side (accepts st_*, drives mem_* requests, errors)
//   slave  : pipeline / memory side
// Signals:
//   st_valid, st_ready, st_addr[31:0], st_data[31:0], st_size[1:0]
//   mem_req, mem_gnt, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0], mem_done
//   align_err, bus_err, err_addr[31:0]
interface store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_done;
  logic        align_err;
  logic        bus_err;
  logic [31:0] err_addr;

  modport master (
    input  st_valid, st_addr, st_data, st_size, mem_gnt, mem_done,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           align_err, bus_err, err_addr
  );

  modport slave (
    output st_valid, st_addr, st_data, st_size, mem_gnt, mem_done,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           align_err, bus_err, err_addr
  );
endinterface

// File: rtl/store_unit.sv
// store_unit: MIPS32 MEM-stage store path. Packs sb/sh/sw data into byte
// lanes, generates byte enables and issues a word-aligned write over a
// req/gnt/done handshake. Misaligned or reserved-size stores pulse align_err;
// a missing acknowledge after TIMEOUT WAIT_ACK cycles pulses bus_err.
// Ports:
//   clk, rst_n (async, active low)
//   bus (store_unit_if.master): st_* request, mem_* write bus, error flags
// Parameter: TIMEOUT (1..255) WAIT_ACK cycles before bus error.
// Option: define UNALIGNED_SPLIT_EN to make misaligned stores legal; stores
// crossing a word boundary are issued as two bus transactions.
module store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  store_unit_if.master bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_ACK
`ifdef UNALIGNED_SPLIT_EN
    , SPLIT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        aerr_q, aerr_d;
  logic        berr_q, berr_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [31:0] saddr_q, saddr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [1:0]  off;
  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;
  logic        pk_bad;
`ifdef UNALIGNED_SPLIT_EN
  logic        split_q, split_d;
  logic [31:0] wd2_q, wd2_d;
  logic [3:0]  be2_q, be2_d;
  logic        pk_split;
  logic [31:0] pk_wdata2;
  logic [3:0]  pk_be2;
`endif

  assign off = bus.st_addr[1:0];

  // Lane packing of the incoming request.
  always_comb begin
    pk_wdata = '0;
    pk_be    = '0;
    pk_bad   = 1'b0;
`ifdef UNALIGNED_SPLIT_EN
    pk_split  = 1'b0;
    pk_wdata2 = '0;
    pk_be2    = '0;
`endif
    case (bus.st_size)
      2'b00: begin
        pk_wdata = {4{bus.st_data[7:0]}};
        pk_be    = 4'b0001 << off;
      end
`ifdef UNALIGNED_SPLIT_EN
      2'b01: begin
        pk_wdata  = {16'h0000, bus.st_data[15:0]} << {off, 3'b000};
        pk_be     = 4'b0011 << off;
        pk_split  = (off == 2'd3);
        pk_wdata2 = {24'h000000, bus.st_data[15:8]};
        pk_be2    = 4'b0001;
      end
      2'b10: begin
        pk_wdata  = bus.st_data << {off, 3'b000};
        pk_be     = 4'b1111 << off;
        pk_split  = (off != 2'd0);
        pk_wdata2 = bus.st_data >> (6'd32 - {1'b0, off, 3'b000});
        pk_be2    = 4'b1111 >> (3'd4 - {1'b0, off});
      end
`else
      2'b01: begin
        pk_wdata = {2{bus.st_data[15:0]}};
        pk_be    = off[1] ? 4'b1100 : 4'b0011;
        pk_bad   = off[0];
      end
      2'b10: begin
        pk_wdata = bus.st_data;
        pk_be    = 4'b1111;
        pk_bad   = (off != 2'd0);
      end
`endif
      default: pk_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    eaddr_d = eaddr_q;
    saddr_d = saddr_q;
    cnt_d   = cnt_q;
`ifdef UNALIGNED_SPLIT_EN
    split_d = split_q;
    wd2_d   = wd2_q;
    be2_d   = be2_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          if (pk_bad) begin
            aerr_d  = 1'b1;
            eaddr_d = bus.st_addr;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = {bus.st_addr[31:2], 2'b00};
            wdata_d = pk_wdata;
            be_d    = pk_be;
            saddr_d = bus.st_addr;
`ifdef UNALIGNED_SPLIT_EN
            split_d = pk_split;
            wd2_d   = pk_wdata2;
            be2_d   = pk_be2;
`endif
          end
        end
      end
      // mem_done is deliberately not looked at here.
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = WAIT_ACK;
          req_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        if (bus.mem_done) begin
          state_d = IDLE;
          cnt_d   = '0;
          be_d    = '0;
`ifdef UNALIGNED_SPLIT_EN
          if (split_q) begin
            state_d = SPLIT;
            split_d = 1'b0;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          berr_d  = 1'b1;
          eaddr_d = saddr_q;
          cnt_d   = '0;
          be_d    = '0;
`ifdef UNALIGNED_SPLIT_EN
          split_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UNALIGNED_SPLIT_EN
      // One idle bus cycle, then the upper-word half of the store.
      SPLIT: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = addr_q + 32'd4;
        wdata_d = wd2_q;
        be_d    = be2_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      eaddr_q <= '0;
      saddr_q <= '0;
      cnt_q   <= '0;
`ifdef UNALIGNED_SPLIT_EN
      split_q <= 1'b0;
      wd2_q   <= '0;
      be2_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      eaddr_q <= eaddr_d;
      saddr_q <= saddr_d;
      cnt_q   <= cnt_d;
`ifdef UNALIGNED_SPLIT_EN
      split_q <= split_d;
      wd2_q   <= wd2_d;
      be2_q   <= be2_d;
`endif
    end
  end

  assign bus.st_ready  = (state_q == IDLE);
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.align_err = aerr_q;
  assign bus.bus_err   = berr_q;
  assign bus.err_addr  = eaddr_q;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- MEM-stage store path for the MIPS32 core: the narrowing, write-direction counterpart of the immediate/load widening logic.
- Takes a sb/sh/sw request (address, 32-bit register data, size), truncates and replicates the data into byte lanes, and generates byte enables.
- Issues the store as a word-aligned write on the data-memory bus with a req/gnt/done handshake.
- Flags misaligned accesses and bus timeouts; holds the pipeline off via st_ready while a store is in flight.

Parameters:
- TIMEOUT, 255: max cycles in WAIT_ACK before bus error; legal range 1..255, 8-bit counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous, active-low reset
- st_valid  input  1  store request valid
- st_ready  output  1  unit can accept a store; high only in IDLE
- st_addr  input  32  byte address
- st_data  input  32  store source register; low bits used for sb/sh
- st_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- mem_req  output  1  bus write request
- mem_gnt  input  1  bus grant; sampled only while mem_req=1
- mem_addr  output  32  word-aligned address; bits[1:0] always 00
- mem_wdata  output  32  lane-placed write data
- mem_be  output  4  byte enables; bit i = byte lane i, little-endian lanes
- mem_done  input  1  write acknowledge
- align_err  output  1  one-cycle pulse: misaligned or reserved-size store
- bus_err  output  1  one-cycle pulse: ack timeout
- err_addr  output  32  st_addr of the last faulting store; holds until the next fault

Behaviour:
- Reset (rst_n=0, async): state IDLE; mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, align_err=0, bus_err=0, err_addr=0, timeout counter=0.
  - Mid-transaction reset abandons the transaction; no error pulse.
- Accept on a rising edge with st_valid & st_ready; request fields are registered at that edge.
- Lane packing, off = st_addr[1:0]:
  - byte: wdata = {4{data[7:0]}}, be = 0001<<off
  - half: wdata = {2{data[15:0]}}, be = off[1] ? 1100 : 0011
  - word: wdata = data, be = 1111
- Alignment and size errors:
  - Misaligned: half with off[0]=1; word with off!=0.
  - A misaligned or reserved-size store is accepted but produces no bus activity.
  - align_err pulses in cycle N+1, err_addr is loaded, and the state stays IDLE.
- State IDLE -> REQ on a legal accept; mem_req=1 from cycle N+1 (registered, zero combinational path from st_*).
- State REQ:
  - mem_req, mem_addr, mem_wdata and mem_be are held stable until mem_gnt=1.
  - On gnt -> WAIT_ACK; mem_req=0 the following cycle.
  - No timeout in REQ.
- State WAIT_ACK:
  - Counter increments each cycle.
  - mem_done -> IDLE and counter cleared; st_ready=1 the next cycle.
  - If the counter reaches TIMEOUT without done: bus_err pulses, err_addr is loaded, -> IDLE.
  - mem_done outside WAIT_ACK is ignored, including the same cycle as gnt.
- Minimum legal store occupancy: accept edge, 1 REQ cycle, 1 WAIT_ACK cycle; 3 cycles accept-to-ready.
- mem_be=0 whenever mem_req=0 and not in WAIT_ACK.
- st_ready=0 in REQ/WAIT_ACK/SPLIT.

Optional Feature:
- Macro: UNALIGNED_SPLIT_EN.
- When defined, misaligned stores are legal and align_err fires only for size 11.
- Packing:
  - half: wdata = data[15:0] << 8*off, be = 0011 << off.
  - word: wdata = data << 8*off, be = 1111 << off (truncated to 4 bits).
- When the access crosses a word (half off=3; word off!=0):
  - Add state SPLIT after the first done.
  - The second transaction uses mem_addr+4, wrapping 0xFFFFFFFC->0x00000000.
  - Second-transaction lanes: half wdata = data[15:0]>>8, be = 0001; word wdata = data >> (32-8*off), be = 1111 >> (4-off).
  - A timeout in either phase pulses bus_err once and returns to IDLE without the second phase.
- When not defined: the unaligned behaviour described under Behaviour applies and the SPLIT state is absent.

Test Plan:
- Legal stores:
  - sb addr=0x1003 data=0xAABBCCDD, gnt and done after 1 cycle -> mem_addr=0x1000, wdata=0xDDDDDDDD, be=1000, st_ready back 3 cycles after accept.
  - sh addr=0x2002 data=0x12345678 -> wdata=0x56785678, be=1100; sw addr=0x2000 -> be=1111, wdata=data.
- Misaligned, macro off: sw addr=0x3001 -> no mem_req, align_err 1-cycle pulse, err_addr=0x3001; size=11 -> same.
- Held grant: gnt held low 5 cycles -> mem_req/addr/wdata/be stable all 5 cycles; mem_done pulsed during REQ ignored.
- Timeout, TIMEOUT=4: no done -> bus_err pulse after 4 WAIT_ACK cycles, err_addr loaded, IDLE.
- Reset during WAIT_ACK -> all outputs 0 immediately.
- Split, macro on: sw addr=0x0FFFFFFD data=0x11223344 -> txn1 addr=0x0FFFFFFC wdata=0x22334400 be=1110; txn2 addr=0x10000000 wdata=0x00000011 be=0001.
